jtag_master: RTL and testbench

Host-side JTAG controller that drives the TAP pins (TCK, TMS, TDI) of an on-chip or off-chip JTAG target and captures its TDO. It accepts one command at a time over a valid/ready interface: TAP reset, IR scan, DR scan, or idle clocks. It returns the captured TDO bits over a valid/ready response interface. It is the initiator counterpart of the JTAG TAP block and is used by the test-access controller or a bench-replacement sequencer.

---
 rtl/jtag_pkg.sv | 26 ++
 rtl/jtag_tck_gen.sv | 41 ++++
 rtl/jtag_master.sv | 215 +++++++++++++++++++++
 tb/tb_jtag_master.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG host controller: op codes, FSM states and
// the fixed TMS walks through the TAP state diagram (all sent LSB first).
package jtag_pkg;

  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_IR    = 2'd1;
  localparam logic [1:0] OP_DR    = 2'd2;
  localparam logic [1:0] OP_IDLE  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SHIFT,
    ST_POST,
    ST_RESP
  } jtag_state_e;

  localparam logic [5:0] RESET_SEQ = 6'b011111;
  localparam logic [3:0] IR_PRE    = 4'b0011;
  localparam logic [2:0] DR_PRE    = 3'b001;
  localparam logic [1:0] POST_SEQ  = 2'b01;

  // Longest prefix: reset walk followed by the IR walk.
  localparam int SEQ_W = 10;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: while run is high TCK toggles every TCK_DIV clk cycles; rise/fall
// strobe in the clk cycle whose closing edge moves TCK high/low.
module jtag_tck_gen
  import jtag_pkg::*;
#(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tck,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap = run && (cnt == CNT_W'(TCK_DIV - 1));
  assign rise = wrap && !tck;
  assign fall = wrap && tck;

  // Dropping run parks TCK low and restarts the half-period count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!run) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      tck <= !tck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jtag_master.sv
// Host-side JTAG controller: runs one TAP reset / IR scan / DR scan / idle
// command at a time and returns the captured TDO bits. LEN_W must be >= 4.
module jtag_master
  import jtag_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int LEN_W   = 7,
  parameter int TCK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              TCK,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO,
  output jtag_state_e       dbg_state
);

  // Handshakes: a command moves on a clk edge with cmd_valid & cmd_ready high,
  // a response on an edge with rsp_valid & rsp_ready high; valid never drops
  // without its handshake and the payload is held stable while valid is high.

  jtag_state_e       state_q, state_n;
  logic [1:0]        op_q, op_n;
  logic [LEN_W-1:0]  len_q, len_n, cnt_q, cnt_n, len_c, pre_len;
  logic [DATA_W-1:0] data_q, data_n, mask_q, mask_n, rsp_q, rsp_n;
  logic [SEQ_W-1:0]  seq_q, seq_n, pre_seq;
  logic [3:0]        ir_pre;
  logic [2:0]        dr_pre;
  logic              tms_q, tms_n, tdi_q, tdi_n, sync_q, sync_n, alive_q;
  logic              run, tck_rise, tck_fall;

  assign run = (state_q == ST_PRE) || (state_q == ST_SHIFT) || (state_q == ST_POST);

  jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .tck  (TCK),
    .rise (tck_rise),
    .fall (tck_fall)
  );

  assign cmd_ready = alive_q && (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_q;
  assign TMS       = tms_q;
  assign TDI       = tdi_q;
  assign dbg_state = state_q;

  always_comb begin
    state_n = state_q;
    op_n    = op_q;
    len_n   = len_q;
    cnt_n   = cnt_q;
    data_n  = data_q;
    mask_n  = mask_q;
    rsp_n   = rsp_q;
    seq_n   = seq_q;
    tms_n   = tms_q;
    tdi_n   = tdi_q;
    sync_n  = sync_q;

    len_c = (cmd_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : cmd_len;

    // A zero-length scan leaves Capture straight for Exit1.
    ir_pre = IR_PRE;
    dr_pre = DR_PRE;
    if (len_c == '0) begin
      ir_pre[3] = 1'b1;
      dr_pre[2] = 1'b1;
    end

    pre_seq = '0;
    pre_len = len_c;
    case (cmd_op)
      OP_RESET: begin
        pre_seq = SEQ_W'(RESET_SEQ);
        pre_len = LEN_W'(6);
      end
      OP_IR: begin
        pre_seq = sync_q ? SEQ_W'(ir_pre) : {ir_pre, RESET_SEQ};
        pre_len = sync_q ? LEN_W'(4) : LEN_W'(10);
      end
      OP_DR: begin
        pre_seq = sync_q ? SEQ_W'(dr_pre) : SEQ_W'({dr_pre, RESET_SEQ});
        pre_len = sync_q ? LEN_W'(3) : LEN_W'(9);
      end
      default: ;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_n   = cmd_op;
          len_n  = len_c;
          data_n = cmd_data;
          rsp_n  = '0;
          if (cmd_op == OP_IDLE && len_c == '0) begin
            state_n = ST_RESP;
          end else begin
            state_n = ST_PRE;
            seq_n   = pre_seq;
            cnt_n   = pre_len;
            tms_n   = pre_seq[0];
            tdi_n   = 1'b0;
          end
        end
      end
      ST_PRE: begin
        if (tck_fall) begin
          if (cnt_q == LEN_W'(1)) begin
            if (op_q == OP_IDLE) begin
              state_n = ST_RESP;
            end else if (op_q == OP_RESET || len_q == '0) begin
              // Reset ends in Run-Test/Idle; empty scans go on to Update.
              state_n = (op_q == OP_RESET) ? ST_RESP : ST_POST;
              sync_n  = (op_q == OP_RESET) ? 1'b1 : sync_q;
              seq_n   = SEQ_W'(POST_SEQ);
              cnt_n   = LEN_W'(2);
              tms_n   = (op_q == OP_RESET) ? tms_q : POST_SEQ[0];
            end else begin
              state_n = ST_SHIFT;
              cnt_n   = len_q;
              mask_n  = DATA_W'(1);
              tdi_n   = data_q[0];
              tms_n   = (len_q == LEN_W'(1));
            end
          end else begin
            seq_n = seq_q >> 1;
            cnt_n = cnt_q - 1'b1;
            tms_n = seq_q[1];
          end
        end
      end
      ST_SHIFT: begin
        if (tck_rise && TDO) begin
          rsp_n = rsp_q | mask_q;
        end
        if (tck_fall) begin
          if (cnt_q == LEN_W'(1)) begin
            state_n = ST_POST;
            seq_n   = SEQ_W'(POST_SEQ);
            cnt_n   = LEN_W'(2);
            tms_n   = POST_SEQ[0];
            tdi_n   = 1'b0;
          end else begin
            cnt_n  = cnt_q - 1'b1;
            data_n = data_q >> 1;
            mask_n = mask_q << 1;
            tdi_n  = data_q[1];
            tms_n  = (cnt_q == LEN_W'(2));
          end
        end
      end
      ST_POST: begin
        if (tck_fall) begin
          if (cnt_q == LEN_W'(1)) begin
            state_n = ST_RESP;
            sync_n  = 1'b1;
          end else begin
            seq_n = seq_q >> 1;
            cnt_n = cnt_q - 1'b1;
            tms_n = seq_q[1];
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_RESET;
      len_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      rsp_q   <= '0;
      seq_q   <= '0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      sync_q  <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_n;
      op_q    <= op_n;
      len_q   <= len_n;
      cnt_q   <= cnt_n;
      data_q  <= data_n;
      mask_q  <= mask_n;
      rsp_q   <= rsp_n;
      seq_q   <= seq_n;
      tms_q   <= tms_n;
      tdi_q   <= tdi_n;
      sync_q  <= sync_n;
      alive_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master: drives commands against a behavioural TAP with an
// 8-bit data register and scores responses and TMS/TDI traces.
module tb_jtag_master;
  import jtag_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [6:0]  cmd_len = '0;
  logic [63:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic        TCK, TMS, TDI, TDO;
  jtag_state_e dbg_state;

  jtag_master #(.DATA_W(64), .LEN_W(7), .TCK_DIV(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_len  (cmd_len),
    .cmd_data (cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .TCK      (TCK),
    .TMS      (TMS),
    .TDI      (TDI),
    .TDO      (TDO),
    .dbg_state(dbg_state)
  );

  // ---------------- TAP target model ----------------
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_e;

  tap_e       tap_st = TLR;
  logic [7:0] tap_dr = 8'hA5;
  logic [3:0] tap_ir = 4'h0;
  logic       tdo_m = 1'b0;
  logic       tdo_tie = 1'b0;

  assign TDO = tdo_tie | tdo_m;

  always @(posedge TCK) begin
    if (tap_st == SH_DR) tap_dr <= {TDI, tap_dr[7:1]};
    if (tap_st == SH_IR) tap_ir <= {TDI, tap_ir[3:1]};
    case (tap_st)
      TLR:    tap_st <= TMS ? TLR    : RTI;
      RTI:    tap_st <= TMS ? SEL_DR : RTI;
      SEL_DR: tap_st <= TMS ? SEL_IR : CAP_DR;
      CAP_DR: tap_st <= TMS ? EX1_DR : SH_DR;
      SH_DR:  tap_st <= TMS ? EX1_DR : SH_DR;
      EX1_DR: tap_st <= TMS ? UPD_DR : PAU_DR;
      PAU_DR: tap_st <= TMS ? EX2_DR : PAU_DR;
      EX2_DR: tap_st <= TMS ? UPD_DR : SH_DR;
      UPD_DR: tap_st <= TMS ? SEL_DR : RTI;
      SEL_IR: tap_st <= TMS ? TLR    : CAP_IR;
      CAP_IR: tap_st <= TMS ? EX1_IR : SH_IR;
      SH_IR:  tap_st <= TMS ? EX1_IR : SH_IR;
      EX1_IR: tap_st <= TMS ? UPD_IR : PAU_IR;
      PAU_IR: tap_st <= TMS ? EX2_IR : PAU_IR;
      EX2_IR: tap_st <= TMS ? UPD_IR : SH_IR;
      default: tap_st <= TMS ? SEL_DR : RTI;
    endcase
  end

  always @(negedge TCK) begin
    tdo_m <= (tap_st == SH_DR) ? tap_dr[0] : (tap_st == SH_IR) ? tap_ir[0] : 1'b0;
  end

  // ---------------- pin monitor ----------------
  logic [127:0] tms_hist = '0;
  logic [127:0] tdi_hist = '0;
  int tms_cnt = 0;
  int hi_cyc = 0;
  int cyc = 0;
  int last_rise = -1;
  int min_iv = 1000;
  int max_iv = 0;
  logic tck_prev = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (TCK) hi_cyc = hi_cyc + 1;
    if (TCK && !tck_prev) begin
      if (tms_cnt < 128) begin
        tms_hist[tms_cnt] = TMS;
        tdi_hist[tms_cnt] = TDI;
      end
      tms_cnt = tms_cnt + 1;
      if (last_rise >= 0) begin
        if (cyc - last_rise < min_iv) min_iv = cyc - last_rise;
        if (cyc - last_rise > max_iv) max_iv = cyc - last_rise;
      end
      last_rise = cyc;
    end
    tck_prev = TCK;
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [7:0]  ref_dr = 8'hA5;
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] op, input int len, input logic [63:0] data,
                      input logic [63:0] exp);
    int n = 0;
    @(negedge clk);
    tms_hist = '0; tdi_hist = '0; tms_cnt = 0; hi_cyc = 0;
    last_rise = -1; min_iv = 1000; max_iv = 0;
    cmd_op = op; cmd_len = 7'(len); cmd_data = data; cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("cmd_accept", 128'(cmd_ready), 128'd1);
    exp_q.push_back(exp);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input int hold);
    int n = 0;
    logic [63:0] exp, d0;
    @(negedge clk);
    while (!rsp_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      check_eq("rsp_timeout", 128'd0, 128'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      check_eq("rsp_unexpected", 128'd1, 128'd0);
      return;
    end
    exp = exp_q.pop_front();
    check_eq("rsp_data", 128'(rsp_data), 128'(exp));
    d0 = rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_valid", 128'(rsp_valid), 128'd1);
      check_eq("hold_data", 128'(rsp_data), 128'(d0));
      check_eq("hold_cmd_ready", 128'(cmd_ready), 128'd0);
      check_eq("hold_tck", 128'(TCK), 128'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("post_rsp_valid", 128'(rsp_valid), 128'd0);
    check_eq("post_cmd_ready", 128'(cmd_ready), 128'd1);
  endtask

  // DR scan through the 8-bit target register: out bit i is the old register for
  // i<8 then the driven data; the register keeps the last 8 bits shifted in.
  task automatic dr_scan(input int len, input logic [63:0] data, input int hold);
    logic [71:0] comb;
    logic [63:0] mask, exp;
    int l;
    l = (len > 64) ? 64 : len;
    comb = {data, ref_dr};
    mask = (l == 64) ? '1 : ((64'd1 << l) - 64'd1);
    exp = comb[63:0] & mask;
    send(OP_DR, len, data, exp);
    get_rsp(hold);
    ref_dr = 8'(comb >> l);
    check_eq("dr_tms_count", 128'(tms_cnt), 128'(l + 5 + ((l == 0) ? 0 : 0)));
    check_eq("tap_dr_after", 128'(tap_dr), 128'(ref_dr));
    check_eq("tap_in_rti", 128'(tap_st), 128'(RTI));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic no_rsp;
    int n;
    repeat (3) @(negedge clk);
    check_eq("rst_tck", 128'(TCK), 128'd0);
    check_eq("rst_tms", 128'(TMS), 128'd1);
    check_eq("rst_tdi", 128'(TDI), 128'd0);
    check_eq("rst_cmd_ready", 128'(cmd_ready), 128'd0);
    check_eq("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    check_eq("rst_rsp_data", 128'(rsp_data), 128'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_eq("ready_after_rst", 128'(cmd_ready), 128'd1);

    // DR scan with the TAP unsynchronised: reset walk first, then 1,0,0.
    send(OP_DR, 8, 64'h3C, 64'hA5);
    get_rsp(0);
    ref_dr = 8'h3C;
    check_eq("unsync_tms_prefix", 128'(tms_hist[8:0]), 128'h05F);
    check_eq("unsync_tms_count", 128'(tms_cnt), 128'd19);
    check_eq("unsync_tdi", 128'(tdi_hist[18:0]), 128'(64'h3C << 9));
    check_eq("tap_dr_3c", 128'(tap_dr), 128'h3C);
    check_eq("tap_rti_1", 128'(tap_st), 128'(RTI));

    // TAP reset command, response held off for 10 clk.
    send(OP_RESET, 0, 64'hFFFF, 64'h0);
    get_rsp(10);
    check_eq("reset_pulses", 128'(tms_cnt), 128'd6);
    check_eq("reset_tms", 128'(tms_hist[5:0]), 128'h1F);
    check_eq("reset_period_min", 128'(min_iv), 128'd4);
    check_eq("reset_period_max", 128'(max_iv), 128'd4);
    check_eq("reset_tck_high", 128'(hi_cyc), 128'd12);
    check_eq("tap_rti_2", 128'(tap_st), 128'(RTI));

    // IR scan with TDO tied high.
    tdo_tie = 1'b1;
    send(OP_IR, 4, 64'h5, 64'hF);
    get_rsp(1);
    tdo_tie = 1'b0;
    check_eq("ir_tms", 128'(tms_hist[9:0]), 128'h183);
    check_eq("ir_tms_count", 128'(tms_cnt), 128'd10);
    check_eq("ir_tdi", 128'(tdi_hist[9:0]), 128'h050);
    check_eq("tap_ir", 128'(tap_ir), 128'h5);

    // Synchronised DR scans: fixed, zero-length, clamped, then random.
    dr_scan(8, 64'h96, 0);
    dr_scan(0, 64'hFF, 0);
    check_eq("dr0_tms", 128'(tms_hist[4:0]), 128'h0D);
    dr_scan(100, {$urandom(), $urandom()}, 2);
    for (int i = 0; i < 4; i++) begin
      dr_scan(int'($urandom_range(1, 64)), {$urandom(), $urandom()}, int'($urandom_range(0, 3)));
    end

    // Idle clocks.
    send(OP_IDLE, 5, 64'hABCD, 64'h0);
    get_rsp(0);
    check_eq("idle5_pulses", 128'(tms_cnt), 128'd5);
    check_eq("idle5_tms", 128'(tms_hist[4:0]), 128'h0);
    send(OP_IDLE, 0, 64'h1, 64'h0);
    get_rsp(0);
    check_eq("idle0_pulses", 128'(tms_cnt), 128'd0);

    // Abort a long DR scan mid-SHIFT with rst_n.
    send(OP_DR, 32, {$urandom(), $urandom()}, 64'h0);
    n = 0;
    while (dbg_state != ST_SHIFT && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("reach_shift", 128'(dbg_state), 128'(ST_SHIFT));
    repeat (21) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("abort_tck", 128'(TCK), 128'd0);
    check_eq("abort_tms", 128'(TMS), 128'd1);
    check_eq("abort_tdi", 128'(TDI), 128'd0);
    check_eq("abort_rsp_valid", 128'(rsp_valid), 128'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    no_rsp = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) no_rsp = 1'b0;
    end
    check_eq("abort_no_rsp", 128'(no_rsp), 128'd1);

    tdo_tie = 1'b1;
    send(OP_IR, 4, 64'hA, 64'hF);
    get_rsp(0);
    tdo_tie = 1'b0;
    check_eq("resync_tms", 128'(tms_hist[9:0]), 128'h0DF);
    check_eq("resync_tms_count", 128'(tms_cnt), 128'd16);
    check_eq("tap_rti_3", 128'(tap_st), 128'(RTI));

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
